// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty scheduler: default widths, duty type and
// the scheduler state encoding.
package pwm_pkg;

    localparam int DUTY_W_DEF = 10;
    localparam int STEP_W_DEF = 4;

    typedef logic [DUTY_W_DEF-1:0] duty_t;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_SETTLED  = 2'd1,
        ST_RAMP     = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_period_cnt.sv
// Free-running PWM period counter with synchronous realign; o_bnd flags the
// last count of each period and is registered alongside the count itself.
module pwm_period_cnt
    import pwm_pkg::*;
#(
    parameter int CNT_W = DUTY_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_bnd
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_bnd;

    // Next count: realign pulse overrides the increment.
    always_comb begin
        w_cnt_nx = r_cnt;
        if (i_clr) begin
            w_cnt_nx = {CNT_W{1'b0}};
        end else begin
            w_cnt_nx = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register plus boundary flag derived from the next count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= {CNT_W{1'b0}};
            r_bnd <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nx;
            r_bnd <= &w_cnt_nx;
        end
    end

    assign o_bnd = r_bnd;

endmodule

// File: rtl/pwm_duty_sched.sv
// Duty scheduler: arbitrates two duty requesters (B over A), holds the target
// and slews the applied duty toward it once per PWM period.
module pwm_duty_sched
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_period_clr,
    input  logic              i_req_a,
    input  logic [DUTY_W-1:0] i_duty_a,
    input  logic              i_req_b,
    input  logic [DUTY_W-1:0] i_duty_b,
    input  logic [STEP_W-1:0] i_step,
    output logic              o_ack_a,
    output logic              o_ack_b,
    output logic [DUTY_W-1:0] o_duty_out,
    output logic              o_busy,
    output logic              o_at_target
);

    pwm_state_e        r_state;
    pwm_state_e        w_state_nx;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] r_target;
    logic              r_ack_a;
    logic              r_ack_b;
    logic              r_busy;
    logic              r_at_target;

    logic              w_bnd;
    logic              w_acc_a;
    logic              w_acc_b;
    logic [DUTY_W-1:0] w_duty_nx;
    logic [DUTY_W-1:0] w_target_nx;
    logic [DUTY_W-1:0] w_slew;
    logic [DUTY_W:0]   w_step_ext;
    logic [DUTY_W:0]   w_tgt_ext;
    logic [DUTY_W:0]   w_up_sum;
    logic [DUTY_W:0]   w_dn_dif;

    pwm_period_cnt #(
        .CNT_W (DUTY_W)
    ) u_period_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_period_clr),
        .o_bnd (w_bnd)
    );

    // One extra bit of headroom keeps the slew arithmetic from wrapping.
    assign w_step_ext = {{(DUTY_W+1-STEP_W){1'b0}}, i_step};
    assign w_tgt_ext  = {1'b0, r_target};
    assign w_up_sum   = {1'b0, r_duty} + w_step_ext;
    assign w_dn_dif   = {1'b0, r_duty} - w_step_ext;

    // Candidate duty for this boundary: one step toward target, clamped at it.
    always_comb begin
        w_slew = r_duty;
        if (i_step == {STEP_W{1'b0}}) begin
            w_slew = r_target;
        end else if (r_target > r_duty) begin
            if (w_up_sum > w_tgt_ext) begin
                w_slew = r_target;
            end else begin
                w_slew = w_up_sum[DUTY_W-1:0];
            end
        end else begin
            // A borrow in the top bit means the floor at zero, which target dominates.
            if (w_dn_dif[DUTY_W] || (w_dn_dif < w_tgt_ext)) begin
                w_slew = r_target;
            end else begin
                w_slew = w_dn_dif[DUTY_W-1:0];
            end
        end
    end

    // Arbitration, target load and state transitions.
    always_comb begin
        w_acc_a     = 1'b0;
        w_acc_b     = 1'b0;
        w_state_nx  = r_state;
        w_duty_nx   = r_duty;
        w_target_nx = r_target;
        if (!i_en) begin
            w_state_nx  = ST_DISABLED;
            w_duty_nx   = {DUTY_W{1'b0}};
            w_target_nx = {DUTY_W{1'b0}};
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    w_state_nx  = ST_SETTLED;
                    w_duty_nx   = {DUTY_W{1'b0}};
                    w_target_nx = {DUTY_W{1'b0}};
                end
                ST_SETTLED, ST_RAMP: begin
                    if (i_req_b && !r_ack_b) begin
                        w_acc_b     = 1'b1;
                        w_target_nx = i_duty_b;
                    end else if (i_req_a && !r_ack_a) begin
                        w_acc_a     = 1'b1;
                        w_target_nx = i_duty_a;
                    end else begin
                        w_target_nx = r_target;
                    end
                    // The slew uses the pre-edge target, so a request landing on
                    // the boundary edge waits for the following boundary.
                    if ((r_state == ST_RAMP) && w_bnd) begin
                        w_duty_nx = w_slew;
                    end else begin
                        w_duty_nx = r_duty;
                    end
                    if (w_duty_nx == w_target_nx) begin
                        w_state_nx = ST_SETTLED;
                    end else begin
                        w_state_nx = ST_RAMP;
                    end
                end
                default: begin
                    w_state_nx  = ST_DISABLED;
                    w_duty_nx   = {DUTY_W{1'b0}};
                    w_target_nx = {DUTY_W{1'b0}};
                end
            endcase
        end
    end

    // State, duty, target and status registers; status follows next-state values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_DISABLED;
            r_duty      <= {DUTY_W{1'b0}};
            r_target    <= {DUTY_W{1'b0}};
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_busy      <= 1'b0;
            r_at_target <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_duty      <= w_duty_nx;
            r_target    <= w_target_nx;
            r_ack_a     <= w_acc_a;
            r_ack_b     <= w_acc_b;
            r_busy      <= (w_state_nx == ST_RAMP);
            r_at_target <= (w_duty_nx == w_target_nx);
        end
    end

    assign o_ack_a     = r_ack_a;
    assign o_ack_b     = r_ack_b;
    assign o_duty_out  = r_duty;
    assign o_busy      = r_busy;
    assign o_at_target = r_at_target;

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Scoreboard bench for pwm_duty_sched: a behavioural model predicts every output
// change, a negedge monitor matches the DUT's changes against that queue.
module tb_pwm_duty_sched;

    localparam int PERIOD = 1024;
    localparam logic [13:0] RST_TUP = {1'b0, 1'b0, 1'b0, 1'b1, 10'd0};

    typedef struct {
        time         t;
        logic [13:0] tup;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       req_a;
    logic [9:0] duty_a;
    logic       req_b;
    logic [9:0] duty_b;
    logic [3:0] step;
    logic       ack_a;
    logic       ack_b;
    logic [9:0] duty_out;
    logic       busy;
    logic       at_target;

    int  checks;
    int  failures;
    ev_t sb[$];

    int  m_cnt;
    int  m_duty;
    int  m_tgt;
    bit  m_dis;
    bit  m_aa;
    bit  m_ab;

    pwm_duty_sched dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_period_clr (clr),
        .i_req_a      (req_a),
        .i_duty_a     (duty_a),
        .i_req_b      (req_b),
        .i_duty_b     (duty_b),
        .i_step       (step),
        .o_ack_a      (ack_a),
        .o_ack_b      (ack_b),
        .o_duty_out   (duty_out),
        .o_busy       (busy),
        .o_at_target  (at_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: outputs derived from duty/target arithmetic and a period count.
    initial begin
        logic [13:0] prev;
        logic [13:0] tup;
        bit          bnd;
        bit          n_aa;
        bit          n_ab;
        int          n_tgt;
        int          d;
        m_cnt = 0; m_duty = 0; m_tgt = 0; m_dis = 1'b1; m_aa = 1'b0; m_ab = 1'b0;
        prev  = RST_TUP;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cnt = 0; m_duty = 0; m_tgt = 0; m_dis = 1'b1; m_aa = 1'b0; m_ab = 1'b0;
            end else begin
                bnd   = (m_cnt == PERIOD - 1);
                m_cnt = clr ? 0 : (m_cnt + 1) % PERIOD;
                n_aa  = 1'b0;
                n_ab  = 1'b0;
                if (!en) begin
                    m_dis = 1'b1; m_duty = 0; m_tgt = 0;
                end else if (m_dis) begin
                    m_dis = 1'b0;
                end else begin
                    n_tgt = m_tgt;
                    if (req_b && !m_ab) begin
                        n_ab = 1'b1; n_tgt = int'(duty_b);
                    end else if (req_a && !m_aa) begin
                        n_aa = 1'b1; n_tgt = int'(duty_a);
                    end
                    if (bnd && m_duty != m_tgt) begin
                        if (step == 4'd0) begin
                            m_duty = m_tgt;
                        end else if (m_tgt > m_duty) begin
                            m_duty = (m_duty + int'(step) > m_tgt) ? m_tgt : m_duty + int'(step);
                        end else begin
                            d = m_duty - int'(step);
                            if (d < 0) d = 0;
                            m_duty = (d < m_tgt) ? m_tgt : d;
                        end
                    end
                    m_tgt = n_tgt;
                end
                m_aa = n_aa;
                m_ab = n_ab;
            end
            tup = {m_aa, m_ab, (!m_dis && m_duty != m_tgt), (m_duty == m_tgt), 10'(m_duty)};
            if (tup != prev) sb.push_back('{t: $time, tup: tup});
            prev = tup;
        end
    end

    // Monitor: every observed DUT output change must match the next predicted event.
    initial begin
        logic [13:0] mprev;
        logic [13:0] cur;
        ev_t         e;
        mprev = RST_TUP;
        forever begin
            @(negedge clk);
            cur = {ack_a, ack_b, busy, at_target, duty_out};
            if (cur !== mprev) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected t=%0t got=%h exp=no_change", $time, cur);
                end else begin
                    e = sb.pop_front();
                    if (e.tup !== cur || $time <= e.t || ($time - e.t) > 10) begin
                        failures++;
                        $display("FAIL sb_event t=%0t got={aa,ab,busy,at,duty}=%h exp=%h at_t=%0t",
                                 $time, cur, e.tup, e.t);
                    end
                end
                mprev = cur;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Advance n cycles; requesters drop their request once they see their ack.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ack_a) req_a = 1'b0;
            if (ack_b) req_b = 1'b0;
        end
    endtask

    task automatic settle(input int budget, input string nm);
        int n;
        n = 0;
        run(2);
        while (busy && n < budget) begin
            run(1);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout busy=%0d after %0d cycles exp=0", nm, busy, budget);
        end
    endtask

    task automatic wait_model_cnt(input int val);
        int n;
        n = 0;
        while (m_cnt != val && n < 2 * PERIOD) begin
            run(1);
            n++;
        end
    endtask

    initial begin
        int n;
        checks = 0; failures = 0;
        rst = 1'b0; en = 1'b0; clr = 1'b0; step = 4'd0;
        req_a = 1'b0; req_b = 1'b0; duty_a = 10'd0; duty_b = 10'd0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_duty", 32'(duty_out), 32'd0);
        check("rst_ack", {30'd0, ack_a, ack_b}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_at_target", 32'(at_target), 32'd1);

        // Ramp up by 4 to 100.
        en = 1'b1; step = 4'd4;
        run(3);
        duty_a = 10'd100; req_a = 1'b1;
        run(3);
        settle(27000, "ramp_up");
        check("ramp_up_duty", 32'(duty_out), 32'd100);
        check("ramp_up_at", 32'(at_target), 32'd1);

        // Ramp down by 7 to 10 with clamp.
        step = 4'd7; duty_b = 10'd10; req_b = 1'b1;
        run(3);
        settle(15000, "ramp_dn");
        check("ramp_dn_duty", 32'(duty_out), 32'd10);

        // Contention: B first, A after B drops; finish with a jump.
        step = 4'd15; duty_a = 10'd500; duty_b = 10'd20; req_a = 1'b1; req_b = 1'b1;
        run(6);
        check("cont_reqs_done", {30'd0, req_a, req_b}, 32'd0);
        run(3 * PERIOD);
        step = 4'd0;
        settle(3000, "cont");
        check("cont_duty", 32'(duty_out), 32'd500);

        // Disable mid-ramp from 300.
        duty_a = 10'd300; req_a = 1'b1;
        run(3);
        settle(3000, "to300");
        step = 4'd15; duty_a = 10'd900; req_a = 1'b1;
        run(3);
        n = 0;
        while (duty_out == 10'd300 && n < 1100) begin
            run(1);
            n++;
        end
        check("dis_ramp_started", 32'(duty_out), 32'd315);
        run(200);
        en = 1'b0;
        run(1);
        check("dis_duty", 32'(duty_out), 32'd0);
        check("dis_busy", 32'(busy), 32'd0);
        duty_b = 10'd50; req_b = 1'b1;
        run(5);
        check("dis_no_ack", {30'd0, ack_a, ack_b}, 32'd0);
        en = 1'b1;
        settle(6000, "reen");
        check("reen_duty", 32'(duty_out), 32'd50);

        // Step 0 request during the boundary cycle, then realign the period.
        step = 4'd0;
        wait_model_cnt(PERIOD - 1);
        duty_a = 10'd1023; req_a = 1'b1;
        run(3);
        run(PERIOD + 50);
        check("step0_duty", 32'(duty_out), 32'd1023);
        run(300);
        clr = 1'b1;
        run(1);
        clr = 1'b0;
        duty_b = 10'd512; req_b = 1'b1;
        run(3);
        run(PERIOD + 50);
        check("clr_duty", 32'(duty_out), 32'd512);

        // Async reset mid-ramp with a B ack pending.
        step = 4'd1; duty_a = 10'd200; req_a = 1'b1;
        run(3);
        run(2 * PERIOD + 10);
        duty_b = 10'd7; req_b = 1'b1;
        #3;
        rst = 1'b1; req_b = 1'b0;
        #1;
        check("arst_duty", 32'(duty_out), 32'd0);
        check("arst_busy_at", {30'd0, busy, at_target}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        run(5);
        check("arst_no_ack", {30'd0, ack_a, ack_b}, 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 12000; c++) begin
            clr = 1'b0;
            if (!req_a && $urandom_range(0, 39) == 0) begin
                duty_a = 10'($urandom_range(0, 1023)); req_a = 1'b1;
            end
            if (!req_b && $urandom_range(0, 79) == 0) begin
                duty_b = 10'($urandom_range(0, 1023)); req_b = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) step = 4'($urandom_range(0, 15));
            if (en && $urandom_range(0, 2499) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 29) == 0) en = 1'b1;
            if ($urandom_range(0, 1499) == 0) clr = 1'b1;
            run(1);
        end
        clr = 1'b0; req_a = 1'b0; req_b = 1'b0;
        run(5);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
